// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH valid-tagged pipeline registers with backward stall, per-stage flush,
// bubble insertion below a frozen section; optional perf counters under PIPE_PERF_EN.
module pipe_reg_chain #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 4,
  parameter int ZERO_INVALID = 1,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DEPTH-1:0]       stall,
  input  logic [DEPTH-1:0]       flush,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [DEPTH*WIDTH-1:0] stage_data,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   perf_clr,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       bubble_cnt
);
  logic [DEPTH-1:0]       eff_stall, nxt_v, prev_v, prev_stall;
  logic [DEPTH*WIDTH-1:0] nxt_d, prev_d;
  always_comb begin
    eff_stall = '0;
    for (int i = 0; i < DEPTH; i++) eff_stall[i] = |(stall >> i);
  end
  // Stage i sees stage i-1 (or the input port for stage 0) as its source.
  assign prev_v     = DEPTH'({stage_valid, in_valid});
  assign prev_stall = DEPTH'({eff_stall, 1'b0});
  assign prev_d     = (DEPTH*WIDTH)'({stage_data, in_data});
  always_comb begin
    nxt_v = stage_valid;
    nxt_d = stage_data;
    for (int i = 0; i < DEPTH; i++) begin
      nxt_v[i] = !flush[i] && (eff_stall[i] ? stage_valid[i] : !prev_stall[i] && prev_v[i]);
      nxt_d[i*WIDTH +: WIDTH] = flush[i] ? '0 :
                                eff_stall[i] ? stage_data[i*WIDTH +: WIDTH] :
                                prev_stall[i] ? (ZERO_INVALID != 0 ? '0 : stage_data[i*WIDTH +: WIDTH]) :
                                (ZERO_INVALID != 0 && !prev_v[i]) ? '0 : prev_d[i*WIDTH +: WIDTH];
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stage_valid <= '0;
      stage_data  <= '0;
    end else begin
      stage_valid <= nxt_v;
      stage_data  <= nxt_d;
    end
  assign in_ready  = ~eff_stall[0];
  assign out_valid = stage_valid[DEPTH-1];
  assign out_data  = stage_data[(DEPTH-1)*WIDTH +: WIDTH];
`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] s_cnt, b_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s_cnt <= '0;
      b_cnt <= '0;
    end else if (perf_clr) begin
      s_cnt <= '0;
      b_cnt <= '0;
    end else begin
      if (eff_stall[0] && ~&s_cnt) s_cnt <= s_cnt + 1'b1;
      if (!out_valid && ~&b_cnt) b_cnt <= b_cnt + 1'b1;
    end
  assign stall_cnt  = s_cnt;
  assign bubble_cnt = b_cnt;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif
endmodule
